button_event_ctrl: RTL and testbench

// Debounce controller for N_BTN raw push-button inputs. Each input is

---
 rtl/btn_evt_pkg.sv | 16 +
 rtl/btn_debounce_chan.sv | 79 +++++++
 rtl/button_event_ctrl.sv | 156 +++++++++++++++
 tb/tb_button_event_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event controller.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_RELEASE = 2'd2,
    EVT_HOLD    = 2'd3
  } evt_kind_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, tick-based debounce of the level,
// hold timer, and a one-cycle event pulse aligned with the state toggle.
module btn_debounce_chan
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEB_TICKS  = 16,
  parameter int unsigned HOLD_TICKS = 500
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      raw,
  input  logic      tick,
  output logic      state,
  output evt_kind_e evt
);

  localparam int unsigned DW = cnt_width(DEB_TICKS - 1);
  localparam int unsigned HW = cnt_width(HOLD_TICKS);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic [1:0]    sync_q, sync_d;
  logic          state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  evt_kind_e     evt_q, evt_d;

  // Next-state: synchroniser shift, debounce counter, hold timer, event pulse.
  always_comb begin
    sync_d     = {sync_q[0], raw};
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    evt_d      = EVT_NONE;

    if (sync_q[1] == state_q) begin
      deb_cnt_d = '0;
    end else if (tick) begin
      if (deb_cnt_q == DEB_LAST) begin
        state_d   = ~state_q;
        deb_cnt_d = '0;
        evt_d     = state_q ? EVT_RELEASE : EVT_PRESS;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    // A release landing on the same tick as the hold expiry keeps the release.
    if (!state_q) begin
      hold_cnt_d = '0;
    end else if (tick && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      if ((hold_cnt_q == HOLD_MAX - 1'b1) && (evt_d == EVT_NONE)) begin
        evt_d = EVT_HOLD;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= '0;
      state_q    <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      evt_q      <= EVT_NONE;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      evt_q      <= evt_d;
    end
  end

  assign state = state_q;
  assign evt   = evt_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Debounce controller: shared tick prescaler, per-channel debouncers,
// one pending event slot per channel, round-robin arbitration onto a
// registered valid/ready event stream, sticky overflow on dropped events.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned DEB_TICKS  = 16,
  parameter int unsigned HOLD_TICKS = 500
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_state,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [1:0]               evt_kind,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int unsigned IW = $clog2(N_BTN);
  localparam int unsigned PW = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          tick;

  evt_kind_e     chan_evt [N_BTN];
  evt_kind_e     slot_q [N_BTN];
  evt_kind_e     slot_d [N_BTN];

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          evt_valid_q, evt_valid_d;
  logic [IW-1:0] evt_id_q, evt_id_d;
  evt_kind_e     evt_kind_q, evt_kind_d;
  logic          overflow_q, overflow_d;

  logic          load;
  logic          grant_hit;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] scan_id;
  logic [N_BTN-1:0] grant_vec;

  // Prescaler: free-running 0..TICK_DIV-1, tick on the last count.
  always_comb begin
    tick      = (pre_cnt_q == TICK_LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEB_TICKS  (DEB_TICKS),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_chan (
      .clk    (clk),
      .resetn (resetn),
      .raw    (btn_raw[g]),
      .tick   (tick),
      .state  (btn_state[g]),
      .evt    (chan_evt[g])
    );
  end

  // Round-robin search: first pending slot after rr_ptr, wrapping.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    for (int unsigned k = 1; k <= N_BTN; k++) begin
      scan_id = IW'((32'(rr_ptr_q) + k) % N_BTN);
      if (!grant_hit && (slot_q[scan_id] != EVT_NONE)) begin
        grant_hit = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  // Output register: reload when empty or when the current event is taken.
  always_comb begin
    load        = !evt_valid_q || evt_ready;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_kind_d  = evt_kind_q;
    rr_ptr_d    = rr_ptr_q;
    grant_vec   = '0;
    if (load) begin
      if (grant_hit) begin
        evt_valid_d         = 1'b1;
        evt_id_d            = grant_id;
        evt_kind_d          = slot_q[grant_id];
        rr_ptr_d            = grant_id;
        grant_vec[grant_id] = 1'b1;
      end else begin
        evt_valid_d = 1'b0;
        evt_id_d    = '0;
        evt_kind_d  = EVT_NONE;
      end
    end
  end

  // Pending slots and overflow; a new event overrides a same-cycle grant clear,
  // and a drop overrides a same-cycle clear_ovf.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_ovf) begin
      overflow_d = 1'b0;
    end
    for (int unsigned i = 0; i < N_BTN; i++) begin
      slot_d[i] = slot_q[i];
      if (grant_vec[i]) begin
        slot_d[i] = EVT_NONE;
      end
      if (chan_evt[i] != EVT_NONE) begin
        if ((slot_q[i] == EVT_NONE) || grant_vec[i]) begin
          slot_d[i] = chan_evt[i];
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_kind_q  <= EVT_NONE;
      overflow_q  <= 1'b0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        slot_q[i] <= EVT_NONE;
      end
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_kind_q  <= evt_kind_d;
      overflow_q  <= overflow_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_kind  = evt_kind_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with small debounce/hold constants.
`timescale 1ns/1ps
module tb_button_event_ctrl;
  import btn_evt_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned TD   = 4;
  localparam int unsigned DEB  = 3;
  localparam int unsigned HOLD = 10;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_state;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [1:0]   evt_id;
  logic [1:0]   evt_kind;
  logic         overflow;
  logic         clear_ovf = 1'b0;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  // Accepted events as {id, kind}, with the cycle they were taken.
  logic [3:0]  q_evt [$];
  int unsigned q_cyc [$];

  button_event_ctrl #(
    .N_BTN      (N),
    .TICK_DIV   (TD),
    .DEB_TICKS  (DEB),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_raw   (btn_raw),
    .btn_state (btn_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_kind  (evt_kind),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      q_evt.push_back({evt_id, evt_kind});
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input int unsigned ch, input logic lvl,
                            output int unsigned n);
    n = 0;
    while ((btn_state[ch] !== lvl) && (n < 200)) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(btn_state[ch]), 32'(lvl));
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n;
    n = 0;
    while ((evt_valid !== 1'b1) && (n < 50)) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(evt_valid), 32'd1);
  endtask

  task automatic clear_q();
    q_evt.delete();
    q_cyc.delete();
  endtask

  task automatic check_q(input string tag, input int unsigned idx, input logic [3:0] exp);
    logic [3:0] got;
    got = (q_evt.size() > idx) ? q_evt[idx] : 4'hx;
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    cycles(3);
    resetn = 1'b1;
    cycles(2);
  endtask

  initial begin
    int unsigned n;
    int unsigned c0;
    logic seen;
    logic stable;

    // Reset state
    cycles(3);
    check("rst_state", 32'(btn_state), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id", 32'(evt_id), 0);
    check("rst_kind", 32'(evt_kind), 0);
    check("rst_ovf", 32'(overflow), 0);
    resetn = 1'b1;
    cycles(2);

    // 1: single press on channel 1, then release before HOLD
    evt_ready = 1'b1;
    clear_q();
    btn_raw[1] = 1'b1;
    wait_state("t1_press_state", 1, 1'b1, n);
    check("t1_deb_time_11_to_14", 32'((n >= 11) && (n <= 14)), 1);
    check("t1_only_ch1", 32'(btn_state), 32'h2);
    c0 = cyc;
    wait_valid("t1_valid");
    check("t1_latency", cyc - c0, 2);
    btn_raw[1] = 1'b0;
    wait_state("t1_release_state", 1, 1'b0, n);
    cycles(4);
    check("t1_evt_count", q_evt.size(), 2);
    check_q("t1_evt0_press1", 0, {2'd1, EVT_PRESS});
    check_q("t1_evt1_release1", 1, {2'd1, EVT_RELEASE});

    // 2: bouncing shorter than the debounce window is ignored
    clear_q();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = ~btn_raw[0];
      repeat (6) begin
        @(posedge clk); #1;
        if (btn_state[0]) seen = 1'b1;
      end
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (btn_state[0]) seen = 1'b1;
    end
    check("t2_state_never_high", 32'(seen), 0);
    check("t2_no_events", q_evt.size(), 0);

    // 3: long press on channel 2 gives PRESS, one HOLD, RELEASE
    clear_q();
    btn_raw[2] = 1'b1;
    wait_state("t3_press_state", 2, 1'b1, n);
    cycles(20 * TD);
    btn_raw[2] = 1'b0;
    wait_state("t3_release_state", 2, 1'b0, n);
    cycles(4);
    check("t3_evt_count", q_evt.size(), 3);
    check_q("t3_evt0_press2", 0, {2'd2, EVT_PRESS});
    check_q("t3_evt1_hold2", 1, {2'd2, EVT_HOLD});
    check_q("t3_evt2_release2", 2, {2'd2, EVT_RELEASE});
    check("t3_hold_delay", (q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : 0, HOLD * TD);

    // 4: all channels at once, round-robin from rr_ptr=0
    apply_reset();
    clear_q();
    btn_raw = '1;
    wait_state("t4_press_state", 0, 1'b1, n);
    check("t4_all_pressed", 32'(btn_state), 32'hF);
    cycles(6);
    check("t4_press_count", q_evt.size(), 4);
    check_q("t4_evt0", 0, {2'd1, EVT_PRESS});
    check_q("t4_evt1", 1, {2'd2, EVT_PRESS});
    check_q("t4_evt2", 2, {2'd3, EVT_PRESS});
    check_q("t4_evt3", 3, {2'd0, EVT_PRESS});
    check("t4_back_to_back", (q_cyc.size() > 3) ? q_cyc[3] - q_cyc[0] : 0, 3);
    btn_raw = '0;
    wait_state("t4_release_state", 0, 1'b0, n);
    cycles(8);
    check("t4_total_count", q_evt.size(), 8);
    check_q("t4_evt4", 4, {2'd1, EVT_RELEASE});
    check_q("t4_evt7", 7, {2'd0, EVT_RELEASE});

    // 5: stalled consumer, stable output, overflow and its clear
    clear_q();
    evt_ready = 1'b0;
    btn_raw[3] = 1'b1;
    wait_state("t5_press_state", 3, 1'b1, n);
    cycles(2);
    check("t5_valid", 32'(evt_valid), 1);
    check("t5_id", 32'(evt_id), 3);
    check("t5_kind", 32'(evt_kind), 32'(EVT_PRESS));
    stable = 1'b1;
    btn_raw[3] = 1'b0;
    n = 0;
    while ((btn_state[3] !== 1'b0) && (n < 200)) begin
      @(posedge clk); #1;
      n++;
      if (!(evt_valid && (evt_id == 2'd3) && (evt_kind == 2'd1))) stable = 1'b0;
    end
    check("t5_release_state", 32'(btn_state[3]), 0);
    cycles(2);
    check("t5_ovf_slot_absorbs", 32'(overflow), 0);
    btn_raw[3] = 1'b1;
    n = 0;
    while ((btn_state[3] !== 1'b1) && (n < 200)) begin
      @(posedge clk); #1;
      n++;
      if (!(evt_valid && (evt_id == 2'd3) && (evt_kind == 2'd1))) stable = 1'b0;
    end
    check("t5_repress_state", 32'(btn_state[3]), 1);
    cycles(2);
    check("t5_ovf_set", 32'(overflow), 1);
    check("t5_output_stable", 32'(stable), 1);
    clear_ovf = 1'b1;
    cycles(1);
    clear_ovf = 1'b0;
    check("t5_ovf_cleared", 32'(overflow), 0);
    evt_ready = 1'b1;
    cycles(3);
    check("t5_drain_count", q_evt.size(), 2);
    check_q("t5_drain0", 0, {2'd3, EVT_PRESS});
    check_q("t5_drain1", 1, {2'd3, EVT_RELEASE});
    btn_raw[3] = 1'b0;
    wait_state("t5_final_release", 3, 1'b0, n);
    cycles(4);
    check("t5_final_count", q_evt.size(), 3);
    check_q("t5_final_evt", 2, {2'd3, EVT_RELEASE});

    // 6: reset mid-debounce with an event held at the output
    clear_q();
    evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    wait_state("t6_press_state", 2, 1'b1, n);
    cycles(2);
    check("t6_pre_valid", 32'(evt_valid), 1);
    btn_raw[1] = 1'b1;
    cycles(5);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_state", 32'(btn_state), 0);
    check("t6_rst_valid", 32'(evt_valid), 0);
    check("t6_rst_id", 32'(evt_id), 0);
    check("t6_rst_kind", 32'(evt_kind), 0);
    check("t6_rst_ovf", 32'(overflow), 0);
    btn_raw = '0;
    cycles(3);
    resetn = 1'b1;
    evt_ready = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if ((btn_state != '0) || evt_valid) seen = 1'b1;
    end
    check("t6_no_spurious_activity", 32'(seen), 0);
    check("t6_no_events", q_evt.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
